// File: rtl/led_sequencer_pkg.sv
// rtl/led_sequencer_pkg.sv - led_pkg: mode/direction types and the per-mode seed pattern
package led_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        COUNT  = 2'd3
    } led_mode_t;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_t;

    localparam int MAX_LEDS = 16;

    // Starting pattern of a mode, right-aligned in a MAX_LEDS-wide word
    function automatic logic [MAX_LEDS-1:0] seed(led_mode_t mode, int n);
        case (mode)
            ROT_R:   seed = MAX_LEDS'(1) << (n - 1);
            COUNT:   seed = '0;
            default: seed = MAX_LEDS'(1);
        endcase
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - tick/mode inputs and LED/wrap outputs of the sequencer
interface led_sequencer_if #(
    parameter int NUM_LEDS = 4
);
    logic                tick_in;
    logic [1:0]          sw;
    logic [NUM_LEDS-1:0] led;
    logic                wrap;

    modport master (output tick_in, output sw, input led, input wrap);
    modport slave  (input tick_in, input sw, output led, output wrap);
endinterface

// File: rtl/led_sequencer_step_qual.sv
// rtl/led_sequencer_step_qual.sv - tick qualifier, rising-edge detect when LED_SEQ_EDGE_EN is defined
module led_step_qual (
    input  logic clk_in,
    input  logic rst_n,
    input  logic tick_in,
    output logic step
);
`ifdef LED_SEQ_EDGE_EN
    logic tick_dly_d;
    logic tick_dly_q;

    // Previous tick level for edge detection
    always_comb begin
        tick_dly_d = tick_in;
    end

    // Tick history register, cleared so a tick high out of reset counts as an edge
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            tick_dly_q <= 1'b0;
        end else begin
            tick_dly_q <= tick_dly_d;
        end
    end

    assign step = tick_in & ~tick_dly_q;
`else
    logic unused_clk_rst;

    // Divider already delivers single-cycle pulses, so every high cycle is a step
    assign unused_clk_rst = clk_in ^ rst_n;
    assign step           = tick_in;
`endif
endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - steps an LED pattern per tick in one of four modes (option: LED_SEQ_EDGE_EN)
module led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    led_sequencer_if.slave     bus
);
    localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

    logic                step;
    led_mode_t           mode_d, mode_q;
    led_mode_t           active_d, active_q;
    dir_t                dir_d, dir_q;
    logic [NUM_LEDS-1:0] led_d, led_q;
    logic                wrap_d, wrap_q;
    logic [MAX_LEDS-1:0] seed_cur_w, seed_new_w;
    logic [NUM_LEDS-1:0] seed_cur;
    logic                one_hot;
    logic                advanced;

    led_step_qual u_step_qual (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .tick_in (bus.tick_in),
        .step    (step)
    );

    // Next pattern, mode and direction for the current step
    always_comb begin
        mode_d     = led_mode_t'(bus.sw);
        active_d   = active_q;
        dir_d      = dir_q;
        led_d      = led_q;
        wrap_d     = 1'b0;
        advanced   = 1'b0;
        seed_cur_w = seed(active_q, NUM_LEDS);
        seed_new_w = seed(mode_q, NUM_LEDS);
        seed_cur   = seed_cur_w[NUM_LEDS-1:0];
        one_hot    = (led_q != '0) && ((led_q & (led_q - LED_ONE)) == '0);
        if (step) begin
            if (mode_q != active_q) begin
                active_d = mode_q;
                led_d    = seed_new_w[NUM_LEDS-1:0];
                dir_d    = UP;
            end else begin
                case (active_q)
                    ROT_L: begin
                        if (one_hot) begin
                            led_d    = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                            advanced = 1'b1;
                        end else begin
                            led_d = seed_cur;
                        end
                    end
                    ROT_R: begin
                        if (one_hot) begin
                            led_d    = {led_q[0], led_q[NUM_LEDS-1:1]};
                            advanced = 1'b1;
                        end else begin
                            led_d = seed_cur;
                        end
                    end
                    BOUNCE: begin
                        if (!one_hot) begin
                            led_d = seed_cur;
                            dir_d = UP;
                        end else begin
                            advanced = 1'b1;
                            if (dir_q == UP) begin
                                if (led_q[NUM_LEDS-1]) begin
                                    led_d = led_q >> 1;
                                    dir_d = DN;
                                end else begin
                                    led_d = led_q << 1;
                                end
                            end else begin
                                if (led_q[0]) begin
                                    led_d = led_q << 1;
                                    dir_d = UP;
                                end else begin
                                    led_d = led_q >> 1;
                                end
                            end
                        end
                    end
                    default: begin
                        led_d    = led_q + LED_ONE;
                        advanced = 1'b1;
                    end
                endcase
                wrap_d = advanced && (led_d == seed_cur);
            end
        end
    end

    // Mode FSM and registered outputs; reset wins over a same-cycle tick
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            mode_q   <= ROT_L;
            active_q <= ROT_L;
            dir_q    <= UP;
            led_q    <= LED_ONE;
            wrap_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            active_q <= active_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer with NUM_LEDS=4
module tb_led_sequencer;

    typedef struct {
        string    tag;
        bit [3:0] led;
        bit       wrap;
    } exp_t;

    logic clk_in;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    bit [3:0] m_led;
    int       m_mode;
    bit       m_dn;
    bit       m_wrap;

    led_sequencer_if #(.NUM_LEDS(4)) bus ();

    led_sequencer #(.NUM_LEDS(4)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #4 clk_in = ~clk_in;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit [3:0] seed_of(input int mode);
        case (mode)
            1:       return 4'b1000;
            3:       return 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

    // Reference model: one step with the mode register holding mode_sel
    task automatic model_step(input int mode_sel);
        m_wrap = 1'b0;
        if (mode_sel != m_mode) begin
            m_mode = mode_sel;
            m_led  = seed_of(mode_sel);
            m_dn   = 1'b0;
        end else begin
            case (m_mode)
                0: m_led = {m_led[2:0], m_led[3]};
                1: m_led = {m_led[0], m_led[3:1]};
                2: begin
                    if (!m_dn) begin
                        if (m_led == 4'b1000) begin m_led = 4'b0100; m_dn = 1'b1; end
                        else m_led = m_led << 1;
                    end else begin
                        if (m_led == 4'b0001) begin m_led = 4'b0010; m_dn = 1'b0; end
                        else m_led = m_led >> 1;
                    end
                end
                default: m_led = m_led + 4'd1;
            endcase
            m_wrap = (m_led == seed_of(m_mode));
        end
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_led"}, int'(bus.led), int'(e.led));
            check({e.tag, "_wrap"}, int'(bus.wrap), int'(e.wrap));
        end
    endtask

    // Hold tick_in high for n cycles; called at posedge+1
    task automatic hold_tick(input string tag, input int n);
        exp_t e;
`ifdef LED_SEQ_EDGE_EN
        model_step(int'(bus.sw));
`else
        for (int i = 0; i < n; i++) model_step(int'(bus.sw));
`endif
        e.tag  = tag;
        e.led  = m_led;
        e.wrap = m_wrap;
        sb.push_back(e);
        bus.tick_in = 1'b1;
        repeat (n) @(posedge clk_in);
        #1 bus.tick_in = 1'b0;
        @(negedge clk_in);
        compare_next();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_sw(input logic [1:0] v);
        bus.sw = v;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bus.tick_in = 1'b1;
        bus.sw      = 2'd0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_led", int'(bus.led), 1);
        check("rst_wrap", int'(bus.wrap), 0);
        rst_n       = 1'b1;
        bus.tick_in = 1'b0;
        m_led  = 4'b0001;
        m_mode = 0;
        m_dn   = 1'b0;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 4; i++) hold_tick("rotl", 1);

        set_sw(2'd1);
        for (int i = 0; i < 4; i++) hold_tick("rotr", 1);

        set_sw(2'd2);
        for (int i = 0; i < 9; i++) hold_tick("bounce", 1);

        set_sw(2'd3);
        for (int i = 0; i < 17; i++) hold_tick("count", 1);

        set_sw(2'd1);
        repeat (3) @(posedge clk_in);
        #1;
        check("swchg_hold_led", int'(bus.led), 0);
        check("swchg_hold_wrap", int'(bus.wrap), 0);
        set_sw(2'd3);

        hold_tick("held5", 5);

        rst_n = 1'b0;
        @(posedge clk_in);
        #1;
        check("midrst_led", int'(bus.led), 1);
        check("midrst_wrap", int'(bus.wrap), 0);
        bus.sw = 2'd0;
        rst_n  = 1'b1;
        m_led  = 4'b0001;
        m_mode = 0;
        m_dn   = 1'b0;
        @(posedge clk_in);
        #1;
        hold_tick("midrst_rotl", 1);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
